stream_sink: RTL and testbench
==============================

STREAM_SINK -- requirements
Module: stream_sink

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter WIDTH, default 5, meaning the data width of input_num.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; reset=0 immediately forces the reset state.
REQ-005 prev_valid  input  1  the upstream stage holds a valid beat on input_num.
REQ-006 this_ready  output  1  the block can accept a beat this cycle.
REQ-007 input_num  input  WIDTH  upstream beat data.
REQ-008 run  input  1  enables draining of the FIFO.
REQ-009 clear  input  1  synchronous clear of the counters and the fault state.
REQ-010 stall_mask  input  8  backpressure pattern; a 1 at bit[phase] blocks the pop in that cycle.
REQ-011 expect_num  input  WIDTH  value that the next popped beat must equal.
REQ-012 pass_count  output  8  number of popped beats that matched expect_num.
REQ-013 accept_count  output  8  number of beats accepted from upstream.
REQ-014 last_num  output  WIDTH  data of the most recently popped beat.
REQ-015 occupancy  output  $clog2(DEPTH)+1  number of FIFO entries in use.
REQ-016 state  output  2  FSM state encoding: IDLE=0, ACTIVE=1, FAULT=2.
REQ-017 error  output  1  high while state==FAULT.

Function
REQ-018 this_ready SHALL equal (occupancy < DEPTH), driven from registered state only, with no combinational path from prev_valid, run, stall_mask or expect_num.
REQ-019 A push SHALL occur in any cycle where prev_valid && this_ready, in every FSM state.
REQ-020 phase SHALL be an internal 3-bit counter that increments every cycle out of reset and wraps from 7 to 0.
REQ-021 A pop SHALL occur in a cycle only when state==ACTIVE, occupancy!=0 and stall_mask[phase]==0.
REQ-022 A simultaneous push and pop SHALL leave occupancy unchanged and preserve FIFO order.
REQ-023 A push SHALL be visible to a pop no earlier than the next cycle, giving a minimum latency of 1 cycle from acceptance to pop.
REQ-024 On a pop, last_num SHALL load the popped data on the same clock edge.
REQ-025 On a pop whose data equals expect_num, pass_count SHALL increment by 1 and saturate at 255.
REQ-026 On each push, accept_count SHALL increment by 1 and saturate at 255.
REQ-027 The FSM SHALL move IDLE->ACTIVE when run=1 and clear=0.
REQ-028 The FSM SHALL move ACTIVE->IDLE when run=0 and no mismatch occurs.
REQ-029 The FSM SHALL move ACTIVE->FAULT on a pop whose data differs from expect_num; the mismatched entry is consumed and pass_count is unchanged.
REQ-030 The FSM SHALL move FAULT->IDLE only when clear=1; run is ignored in FAULT.
REQ-031 clear=1 SHALL zero pass_count and accept_count, force state to IDLE, and suppress the pop in that cycle.
REQ-032 clear SHALL NOT flush the FIFO, and a push in the clear cycle SHALL still be stored, leaving accept_count=0.
REQ-033 If mismatch and clear occur in the same cycle, clear SHALL win and the FSM SHALL enter IDLE.
REQ-034 In FAULT, pops SHALL stop, so that once the FIFO fills, this_ready=0 backpressures upstream.
REQ-035 Read and write pointers SHALL wrap modulo DEPTH, and a full FIFO SHALL be distinguished from an empty one by occupancy.

Reset
REQ-036 While reset=0, the block SHALL hold this_ready=1, occupancy=0, pass_count=0, accept_count=0, last_num=0, state=IDLE, error=0 and phase=0, with the pointers zeroed.
REQ-037 A reset asserted mid-operation SHALL discard the FIFO contents within the same cycle.
REQ-038 After reset=1, the first push SHALL be possible on the first rising edge.

Verification
REQ-039 Scenario: run=1, stall_mask=0x00, prev_valid=1 with input_num=2 for 5 cycles, expect_num=2 -> accept_count=5, pass_count=5, occupancy back to 0, and error stays 0.
REQ-040 Scenario: run=0 with 6 beats offered -> 4 accepted, this_ready=0 from the cycle after the 4th push, accept_count=4; then run=1 -> pops resume and this_ready rises.
REQ-041 Scenario: stall_mask=0xAA with the FIFO pre-filled with 4 beats and run=1 -> pops only on even phases, and the FIFO is empty after 8 cycles.
REQ-042 Scenario: beats 2,2,3 with expect_num=2 -> pass_count=2, last_num=3, state=FAULT; then clear=1 -> state=IDLE and counters=0.
REQ-043 Scenario: full FIFO with pass_count=3, then reset=0 asserted asynchronously between edges -> all outputs immediately take their REQ-036 values.
REQ-044 Scenario: 300 matching beats -> pass_count and accept_count saturate at 255 with no wrap.

Source files
------------

// File: rtl/stream_sink.sv
// Stream sink: buffers upstream beats in a small FIFO and drains them under
// run/stall control, counting accepted and matching beats and faulting on a mismatch.
module stream_sink #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    prev_valid,
    output logic                    this_ready,
    input  logic [WIDTH-1:0]        input_num,
    input  logic                    run,
    input  logic                    clear,
    input  logic [7:0]              stall_mask,
    input  logic [WIDTH-1:0]        expect_num,
    output logic [7:0]              pass_count,
    output logic [7:0]              accept_count,
    output logic [WIDTH-1:0]        last_num,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic [1:0]              state,
    output logic                    error
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   OCC_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_FAULT  = 2'd2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [2:0]       phase;
    logic [1:0]       state_nxt;
    logic             push, pop, match;
    logic [WIDTH-1:0] head;

    // Ready depends on the registered fill level only, so upstream sees no comb loop.
    assign this_ready = (occupancy < FULL);
    assign head       = mem[rd_ptr];
    assign push       = prev_valid && this_ready;
    assign pop        = (state == S_ACTIVE) && (occupancy != '0) && !stall_mask[phase] && !clear;
    assign match      = (head == expect_num);

    // Storage needs no reset: reset discards contents by zeroing pointers and fill level.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= input_num;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OCC_ONE;
                2'b01:   occupancy <= occupancy - OCC_ONE;
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) phase <= '0;
        else        phase <= phase + 3'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pass_count   <= '0;
            accept_count <= '0;
            last_num     <= '0;
        end else begin
            if (pop) last_num <= head;
            if (clear)                                 accept_count <= '0;
            else if (push && accept_count != 8'hFF)    accept_count <= accept_count + 8'd1;
            if (clear)                                 pass_count <= '0;
            else if (pop && match && pass_count != 8'hFF) pass_count <= pass_count + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Clear dominates a same-cycle mismatch; a mismatch dominates run dropping.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (run && !clear) state_nxt = S_ACTIVE;
            S_ACTIVE: begin
                if (clear)              state_nxt = S_IDLE;
                else if (pop && !match) state_nxt = S_FAULT;
                else if (!run)          state_nxt = S_IDLE;
            end
            S_FAULT:  if (clear) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        error = (state == S_FAULT);
    end

endmodule

// File: tb/tb_stream_sink.sv
// Scoreboard bench for stream_sink: accepted beats are queued by the stimulus,
// a negedge monitor infers pops from the fill level and checks last_num.
module tb_stream_sink;
    localparam int D = 4;
    localparam int W = 5;

    logic         clk, reset, prev_valid, run, clear;
    logic         this_ready, error;
    logic [W-1:0] input_num, expect_num, last_num;
    logic [7:0]   stall_mask, pass_count, accept_count;
    logic [2:0]   occupancy;
    logic [1:0]   state;

    int n_checks = 0;
    int n_err    = 0;
    logic [W-1:0] exp_q[$];
    logic [2:0]   tb_phase;
    int           mon_occ;
    logic         mon_push;

    stream_sink #(.DEPTH(D), .WIDTH(W)) dut (
        .clk(clk), .reset(reset), .prev_valid(prev_valid), .this_ready(this_ready),
        .input_num(input_num), .run(run), .clear(clear), .stall_mask(stall_mask),
        .expect_num(expect_num), .pass_count(pass_count), .accept_count(accept_count),
        .last_num(last_num), .occupancy(occupancy), .state(state), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) tb_phase <= 3'd0;
        else        tb_phase <= tb_phase + 3'd1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops at the last edge = old level + push - new level.
    always @(negedge clk) begin
        if (!reset) begin
            mon_occ  = 0;
            mon_push = 1'b0;
        end else begin
            automatic int pops = mon_occ + int'(mon_push) - int'(occupancy);
            if (pops == 1) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL pop_underflow: got a pop with last_num %0d, expected no pop", last_num);
                end else begin
                    chk("pop_data", int'(last_num), int'(exp_q.pop_front()));
                end
            end else if (pops != 0) begin
                chk("pop_step", pops, 0);
            end
            mon_occ  = int'(occupancy);
            mon_push = prev_valid && this_ready;
        end
    end

    // Entered and left at posedge+1.
    task automatic beat(input logic pv, input logic [W-1:0] d, output logic acc);
        prev_valid = pv;
        input_num  = d;
        @(negedge clk);
        acc = pv && this_ready;
        if (acc) exp_q.push_back(d);
        @(posedge clk); #1;
        prev_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        logic a;
        repeat (n) beat(1'b0, '0, a);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        logic a;
        int   eocc;
        logic active;
        reset = 1'b0; prev_valid = 1'b0; input_num = '0; run = 1'b0; clear = 1'b0;
        stall_mask = 8'h00; expect_num = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", this_ready, 1);
        chk("rst_occ", occupancy, 0);
        chk("rst_pass", pass_count, 0);
        chk("rst_accept", accept_count, 0);
        chk("rst_last", last_num, 0);
        chk("rst_state", state, 0);
        chk("rst_error", error, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Streaming match: 5 beats of 2
        run = 1'b1; expect_num = 5'd2;
        repeat (5) beat(1'b1, 5'd2, a);
        idle(4);
        chk("s1_accept", accept_count, 5);
        chk("s1_pass", pass_count, 5);
        chk("s1_occ", occupancy, 0);
        chk("s1_error", error, 0);
        chk("s1_last", last_num, 2);

        run = 1'b0; clear = 1'b1; idle(1); clear = 1'b0;
        chk("clr_state", state, 0);
        chk("clr_accept", accept_count, 0);

        // Backpressure with run=0: 6 offered, 4 taken
        for (int i = 0; i < 6; i++) begin
            beat(1'b1, 5'd7, a);
            chk($sformatf("s2_acc%0d", i), a, (i < 4) ? 1 : 0);
        end
        chk("s2_accept", accept_count, 4);
        chk("s2_occ", occupancy, 4);
        chk("s2_ready", this_ready, 0);

        // Drain under stall 0xAA: pops only on even phases
        stall_mask = 8'hAA; run = 1'b1; expect_num = 5'd7;
        eocc = 4; active = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (active && eocc > 0 && !stall_mask[tb_phase]) eocc--;
            active = 1'b1;
            idle(1);
            chk($sformatf("s3_occ%0d", i), occupancy, eocc);
        end
        chk("s3_empty", occupancy, 0);
        chk("s3_ready", this_ready, 1);
        chk("s3_pass", pass_count, 4);

        run = 1'b0; stall_mask = 8'h00; clear = 1'b1; idle(1); clear = 1'b0;

        // Mismatch: 2,2,3 with expect 2
        run = 1'b1; expect_num = 5'd2;
        beat(1'b1, 5'd2, a); beat(1'b1, 5'd2, a); beat(1'b1, 5'd3, a);
        idle(3);
        chk("s4_pass", pass_count, 2);
        chk("s4_last", last_num, 3);
        chk("s4_state", state, 2);
        chk("s4_error", error, 1);
        chk("s4_accept", accept_count, 3);
        for (int i = 0; i < 5; i++) begin
            beat(1'b1, 5'd2, a);
            chk($sformatf("s4_facc%0d", i), a, (i < 4) ? 1 : 0);
        end
        chk("s4_fault_occ", occupancy, 4);
        chk("s4_fault_hold", state, 2);
        clear = 1'b1; idle(1); clear = 1'b0;
        chk("s4_clr_state", state, 0);
        chk("s4_clr_pass", pass_count, 0);
        chk("s4_clr_accept", accept_count, 0);
        chk("s4_clr_keep", occupancy, 4);
        idle(6);
        chk("s4_drain_pass", pass_count, 4);
        chk("s4_drain_occ", occupancy, 0);
        chk("s4_drain_state", state, 1);
        run = 1'b0; idle(1);

        // Push in a clear cycle is stored but not counted
        clear = 1'b1; beat(1'b1, 5'd9, a); clear = 1'b0;
        chk("s5_clr_push_acc", a, 1);
        chk("s5_clr_push_occ", occupancy, 1);
        chk("s5_clr_push_cnt", accept_count, 0);

        // Full FIFO with pass_count=3, then async reset mid-cycle
        run = 1'b1; expect_num = 5'd9;
        beat(1'b1, 5'd9, a); beat(1'b1, 5'd9, a);
        idle(3);
        chk("s6_pass", pass_count, 3);
        run = 1'b0; idle(1);
        repeat (4) beat(1'b1, 5'd9, a);
        chk("s6_full_occ", occupancy, 4);
        chk("s6_full_ready", this_ready, 0);
        chk("s6_queue", exp_q.size(), 4);
        #2;
        reset = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_ready", this_ready, 1);
        chk("arst_occ", occupancy, 0);
        chk("arst_pass", pass_count, 0);
        chk("arst_accept", accept_count, 0);
        chk("arst_last", last_num, 0);
        chk("arst_state", state, 0);
        chk("arst_error", error, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Saturation over 300 matching beats; first beat lands on the first edge
        run = 1'b1; expect_num = 5'd1;
        beat(1'b1, 5'd1, a);
        chk("first_push_acc", a, 1);
        chk("first_push_cnt", accept_count, 1);
        repeat (299) beat(1'b1, 5'd1, a);
        idle(4);
        chk("sat_accept", accept_count, 255);
        chk("sat_pass", pass_count, 255);
        chk("sat_occ", occupancy, 0);
        chk("sat_error", error, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
